// File: rtl/echo_connect_fifo.sv
// Say/heard echo connector with a DEPTH-entry circular FIFO between the say
// method and the heard indication, plus occupancy and wrapping transfer counts.
module echo_connect_fifo #(
  parameter int WIDTH = 192,
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int CNT_W = 11
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             say__ENA,
  input  logic [WIDTH-1:0] say_meth,
  input  logic [WIDTH-1:0] say_v,
  output logic             say__RDY,
  output logic             ind_heard__ENA,
  output logic [WIDTH-1:0] ind_heard_heard_meth,
  output logic [WIDTH-1:0] ind_heard_heard_v,
  input  logic             ind_heard__RDY,
  input  logic             rule_enable,
  output logic             rule_ready,
  output logic [AW:0]      occupancy,
  output logic [CNT_W-1:0] say_count,
  output logic [CNT_W-1:0] heard_count
);

  localparam logic [AW:0]      OCC_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]      OCC_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] meth_mem [DEPTH];
  logic [WIDTH-1:0] v_mem    [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             say_fire;
  logic             respond_rdy;
  logic             respond_fire;

  // Readiness looks only at registered occupancy, so a full FIFO blocks say
  // even in a cycle where respond drains the head.
  assign say__RDY       = (occupancy != OCC_FULL);
  assign say_fire       = say__ENA & say__RDY;
  assign respond_rdy    = (occupancy != '0) & ind_heard__RDY;
  assign rule_ready     = respond_rdy;
  assign respond_fire   = rule_enable & respond_rdy;
  assign ind_heard__ENA = respond_fire;

  assign ind_heard_heard_meth = meth_mem[rd_ptr];
  assign ind_heard_heard_v    = v_mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (say_fire) begin
      meth_mem[wr_ptr] <= say_meth;
      v_mem[wr_ptr]    <= say_v;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occupancy   <= '0;
      say_count   <= '0;
      heard_count <= '0;
    end else begin
      if (say_fire) begin
        wr_ptr    <= wr_ptr + PTR_ONE;
        say_count <= say_count + CNT_ONE;
      end
      if (respond_fire) begin
        rd_ptr      <= rd_ptr + PTR_ONE;
        heard_count <= heard_count + CNT_ONE;
      end
      case ({say_fire, respond_fire})
        2'b10:   occupancy <= occupancy + OCC_ONE;
        2'b01:   occupancy <= occupancy - OCC_ONE;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: tb/tb_echo_connect_fifo.sv
// Scoreboard bench for echo_connect_fifo: stimulus queues expected heard
// payloads, a negedge monitor pops and compares whenever heard fires.
module tb_echo_connect_fifo;
  localparam int WIDTH = 192;
  localparam int AW    = 2;
  localparam int CNT_W = 11;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             say_ena;
  logic [WIDTH-1:0] say_meth, say_v;
  logic             say_rdy;
  logic             heard_ena;
  logic [WIDTH-1:0] heard_meth, heard_v;
  logic             heard_rdy;
  logic             rule_enable;
  logic             rule_ready;
  logic [AW:0]      occupancy;
  logic [CNT_W-1:0] say_count, heard_count;

  logic             d3_say_ena, d3_say_rdy, d3_heard_ena, d3_rule_ready;
  logic [WIDTH-1:0] d3_meth, d3_v, d3_heard_meth, d3_heard_v;
  logic [AW:0]      d3_occ;
  logic [2:0]       d3_say_count, d3_heard_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*WIDTH-1:0] exp_q [$];

  always #5 CLK = ~CLK;

  echo_connect_fifo #(.WIDTH(WIDTH), .DEPTH(4), .AW(AW), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .say__ENA(say_ena), .say_meth(say_meth), .say_v(say_v), .say__RDY(say_rdy),
    .ind_heard__ENA(heard_ena), .ind_heard_heard_meth(heard_meth),
    .ind_heard_heard_v(heard_v), .ind_heard__RDY(heard_rdy),
    .rule_enable(rule_enable), .rule_ready(rule_ready),
    .occupancy(occupancy), .say_count(say_count), .heard_count(heard_count)
  );

  echo_connect_fifo #(.WIDTH(WIDTH), .DEPTH(4), .AW(AW), .CNT_W(3)) dut3 (
    .CLK(CLK), .nRST(nRST),
    .say__ENA(d3_say_ena), .say_meth(d3_meth), .say_v(d3_v), .say__RDY(d3_say_rdy),
    .ind_heard__ENA(d3_heard_ena), .ind_heard_heard_meth(d3_heard_meth),
    .ind_heard_heard_v(d3_heard_v), .ind_heard__RDY(1'b1),
    .rule_enable(1'b1), .rule_ready(d3_rule_ready),
    .occupancy(d3_occ), .say_count(d3_say_count), .heard_count(d3_heard_count)
  );

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic half();
    @(negedge CLK);
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic say(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] v, input bit expect_heard);
    say_ena  = 1'b1;
    say_meth = m;
    say_v    = v;
    if (expect_heard) exp_q.push_back({m, v});
  endtask

  // Monitor: every heard fire must match the oldest outstanding say.
  always @(negedge CLK) begin
    logic [2*WIDTH-1:0] e;
    logic [CNT_W-1:0]   diff;
    if (nRST) begin
      if (heard_ena) begin
        if (exp_q.size() == 0) begin
          chk("heard_unexpected", {191'd0, heard_ena}, '0);
        end else begin
          e = exp_q.pop_front();
          chk("heard_meth", heard_meth, e[2*WIDTH-1:WIDTH]);
          chk("heard_v", heard_v, e[WIDTH-1:0]);
        end
      end
      diff = say_count - heard_count;
      chk("occ_invariant", WIDTH'(occupancy), WIDTH'(diff[AW:0]));
    end
  end

  initial begin
    nRST = 1'b0; say_ena = 1'b0; say_meth = '0; say_v = '0;
    heard_rdy = 1'b1; rule_enable = 1'b1;
    d3_say_ena = 1'b0; d3_meth = '0; d3_v = '0;
    #3;
    chk("rst_say_rdy", WIDTH'(say_rdy), 1);
    chk("rst_rule_ready", WIDTH'(rule_ready), 0);
    chk("rst_heard_ena", WIDTH'(heard_ena), 0);
    chk("rst_occ", WIDTH'(occupancy), 0);
    chk("rst_say_count", WIDTH'(say_count), 0);
    chk("rst_heard_count", WIDTH'(heard_count), 0);
    cyc();
    nRST = 1'b1;
    for (int i = 0; i < 2; i++) begin
      half(); chk("idle_heard_ena", WIDTH'(heard_ena), 0);
      chk("idle_rule_ready", WIDTH'(rule_ready), 0);
      cyc();
    end

    // single say, heard one cycle later
    say(192'h1, 192'h2, 1'b1);
    half(); chk("nobypass_ena", WIDTH'(heard_ena), 0);
    cyc();
    say_ena = 1'b0;
    half(); chk("single_ena", WIDTH'(heard_ena), 1); chk("single_occ", WIDTH'(occupancy), 1);
    cyc();
    half(); chk("single_occ_after", WIDTH'(occupancy), 0);
    chk("single_heard_count", WIDTH'(heard_count), 1);
    cyc();

    // fill to full, extra say ignored, then drain in order
    heard_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      say(WIDTH'(10 + i), WIDTH'(100 + i), 1'b1);
      half(); cyc();
    end
    say(WIDTH'(14), WIDTH'(104), 1'b0);
    half(); chk("full_say_rdy", WIDTH'(say_rdy), 0); chk("full_occ", WIDTH'(occupancy), 4);
    cyc();
    say_ena = 1'b0;
    half(); chk("full_say_count", WIDTH'(say_count), 5); chk("full_occ_hold", WIDTH'(occupancy), 4);
    cyc();
    heard_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      half(); chk("drain_ena", WIDTH'(heard_ena), 1);
      cyc();
    end
    half(); chk("drain_occ", WIDTH'(occupancy), 0); chk("drain_heard_count", WIDTH'(heard_count), 5);
    cyc();

    // steady state with two entries, both sides firing every cycle
    heard_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      say(WIDTH'(20 + i), WIDTH'(200 + i), 1'b1);
      half(); cyc();
    end
    heard_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      say(WIDTH'(22 + i), WIDTH'(202 + i), 1'b1);
      half(); chk("steady_occ", WIDTH'(occupancy), 2); chk("steady_ena", WIDTH'(heard_ena), 1);
      chk("steady_say_rdy", WIDTH'(say_rdy), 1);
      cyc();
    end
    say_ena = 1'b0;
    for (int i = 0; i < 2; i++) begin half(); cyc(); end
    half(); chk("steady_occ_end", WIDTH'(occupancy), 0); chk("steady_say_count", WIDTH'(say_count), 15);
    cyc();

    // scheduler holds off the respond rule
    say(WIDTH'(30), WIDTH'(300), 1'b1);
    half(); cyc();
    say_ena = 1'b0; rule_enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      half(); chk("gated_rule_ready", WIDTH'(rule_ready), 1);
      chk("gated_ena", WIDTH'(heard_ena), 0); chk("gated_occ", WIDTH'(occupancy), 1);
      cyc();
    end
    rule_enable = 1'b1;
    half(); cyc();
    half(); chk("gated_heard_count", WIDTH'(heard_count), 16); cyc();

    // asynchronous reset mid-stream discards queued entries
    heard_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      say(WIDTH'(40 + i), WIDTH'(400 + i), 1'b0);
      half(); cyc();
    end
    say_ena = 1'b0;
    half(); chk("pre_rst_occ", WIDTH'(occupancy), 3); cyc();
    heard_rdy = 1'b1;
    #2 nRST = 1'b0;
    #1;
    chk("async_occ", WIDTH'(occupancy), 0);
    chk("async_say_count", WIDTH'(say_count), 0);
    chk("async_heard_count", WIDTH'(heard_count), 0);
    chk("async_say_rdy", WIDTH'(say_rdy), 1);
    chk("async_rule_ready", WIDTH'(rule_ready), 0);
    chk("async_ena", WIDTH'(heard_ena), 0);
    cyc();
    nRST = 1'b1;
    say(192'hAA, 192'h55, 1'b1);
    half(); cyc();
    say_ena = 1'b0;
    half(); chk("post_rst_ena", WIDTH'(heard_ena), 1); cyc();
    half(); chk("post_rst_occ", WIDTH'(occupancy), 0); cyc();
    chk("scoreboard_empty", WIDTH'(exp_q.size()), 0);

    // narrow counters wrap: 9 transfers through a CNT_W=3 instance
    for (int i = 0; i < 9; i++) begin
      d3_say_ena = 1'b1; d3_meth = WIDTH'(i); d3_v = WIDTH'(i);
      half(); cyc();
    end
    d3_say_ena = 1'b0;
    half(); cyc();
    half();
    chk("wrap_say_count", WIDTH'(d3_say_count), 1);
    chk("wrap_heard_count", WIDTH'(d3_heard_count), 1);
    chk("wrap_occ", WIDTH'(d3_occ), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
